hazard_unit_mc: RTL
===================

# hazard_unit_mc

Parametrised pipeline hazard controller for the five-stage MIPS core (F/D/E/M/W) with multi-cycle divider sequencing and data-SRAM wait handling. Generates forwarding selects for D (branch/jr compare) and E (ALU), load-use/branch/jr stalls, and per-stage stall/flush. Replaces the divider's external ready handshake with an internal counter FSM. Computes the exception/ERET redirect PC. Sits beside the datapath; all outputs are consumed by the pipeline registers and the PC mux.

## Interface
- REG_AW, 5, register-address width
- DIV_CYCLES, 32, E-stage cycles a DIV/DIVU occupies (>=2)
- EXC_VECTOR, 32'hbfc00380, exception entry PC
- ERET_CODE, 32'h0000000e, excepttype value meaning ERET
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- rsD, rtD  in  REG_AW  D-stage source registers
- branchD, jrD  in  1  D-stage branch / jr-or-jalr
- rsE, rtE, writeregE  in  REG_AW  E-stage sources and destination
- regwriteE, memtoregE, divE  in  1  E-stage writes reg / is load / is DIV or DIVU
- writeregM  in  REG_AW;  regwriteM, memtoregM  in  1
- mem_busyM  in  1  data SRAM not yet complete for M-stage access
- excepttypeM, epcM  in  32  exception code (0 = none) and EPC
- writeregW  in  REG_AW;  regwriteW  in  1
- forwardaD, forwardbD  out  1  select M-stage result in D
- forwardaE, forwardbE  out  2  00 regfile, 10 M result, 01 W result
- stallF, stallD, stallE, stallM  out  1
- flushF, flushD, flushE, flushM, flushW  out  1
- div_busy  out  1  divider FSM in BUSY
- div_done  out  1  one-cycle pulse: quotient valid in E this cycle
- newPC  out  32  redirect target;  pc_redirect  out  1  take newPC

## Operation
- Forwarding: register 0 never forwarded. E: M match beats W match (needs regwrite). D: rsD/rtD == writeregM & regwriteM.
- lwstall = memtoregE & rtE!=0 & (rtE==rsD | rtE==rtD).
- branchstall = branchD & ((regwriteE & writeregE!=0 & writeregE∈{rsD,rtD}) | (memtoregM & writeregM!=0 & writeregM∈{rsD,rtD})).
- jrstall = jrD & same condition on rsD only.
- Divider FSM IDLE/BUSY/DONE, counter width clog2(DIV_CYCLES):
  - IDLE: divE & no exception & !mem_busyM -> BUSY, count = DIV_CYCLES-2.
  - BUSY: decrement each cycle unless mem_busyM (hold); at count 0 -> DONE.
  - DONE: div_done=1 for one cycle -> IDLE (back-to-back div re-enters BUSY next cycle).
  - divstall = divE & state!=DONE.
  - Exception in any state -> IDLE next cycle, count cleared.
- Priority (highest first):
  1. exc = excepttypeM!=0: flushF..W=1, all stalls 0, pc_redirect=1.
  2. mem_busyM: stallF..M=1, flushW=1, other flushes 0.
  3. divstall: stallF/D/E=1, flushM=1.
  4. lw/branch/jr stall: stallF/D=1, flushE=1.
- newPC = epcM if excepttypeM==ERET_CODE, else EXC_VECTOR when exc; 0 otherwise (no latch).

## Timing
- Reset (async): FSM IDLE, count 0, div_busy=0, div_done=0. Comb outputs follow inputs; with all inputs 0 every output is 0.
- Forwarding, stall, flush, newPC, pc_redirect: combinational, same cycle as causing inputs.
- DIV occupies E exactly DIV_CYCLES cycles absent mem_busyM: stallE high cycles 1..DIV_CYCLES-1, low and div_done high on cycle DIV_CYCLES.
- Each mem_busyM cycle during BUSY extends the divide by one cycle.
- rst asserted mid-divide: FSM IDLE immediately; divE still high after release restarts a full divide.
- Exception coincident with DONE: div_done suppressed (0), flush wins.

## Test plan
- Forward: rsE=rtE=3, writeregM=3 & regwriteM, writeregW=3 & regwriteW -> forwardaE=forwardbE=10; rsE=0 -> 00.
- Load-use: memtoregE, rtE=5, rsD=5 -> stallF=stallD=flushE=1 one cycle; rtE=0 -> no stall.
- Divide, DIV_CYCLES=32: divE held from cycle 0 -> stallE=1 cycles 0..30, div_done=1 cycle 31, IDLE cycle 32.
- Divide with mem_busyM high 3 cycles mid-BUSY -> div_done at cycle 34; stallF..M=1, flushW=1 during busy.
- Exception in BUSY, excepttypeM=1 -> all flushes=1, newPC=bfc00380, pc_redirect=1, FSM IDLE next cycle; excepttypeM=0e, epcM=0xbfc01234 -> newPC=0xbfc01234.
- rst pulse mid-BUSY -> div_busy=0 immediately without clock edge.

Source files
------------

// File: rtl/hazard_unit_mc.sv
// Hazard controller for the five-stage MIPS pipeline: forwarding selects, load-use/branch/jr
// stalls, multi-cycle divider sequencing, data-SRAM wait handling and exception redirect.
module hazard_unit_mc #(
    parameter int          REG_AW     = 5,
    parameter int          DIV_CYCLES = 32,
    parameter logic [31:0] EXC_VECTOR = 32'hbfc00380,
    parameter logic [31:0] ERET_CODE  = 32'h0000000e
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              branchD,
    input  logic              jrD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic              divE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic              regwriteM,
    input  logic              memtoregM,
    input  logic              mem_busyM,
    input  logic [31:0]       excepttypeM,
    input  logic [31:0]       epcM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteW,
    output logic              forwardaD,
    output logic              forwardbD,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushF,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic              div_busy,
    output logic              div_done,
    output logic [31:0]       newPC,
    output logic              pc_redirect
);

    localparam int              CNT_W    = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divState_t;

    divState_t        divState;
    divState_t        divStateNext;
    logic [CNT_W-1:0] divCount;
    logic [CNT_W-1:0] divCountNext;

    logic exc;
    logic eHitRs;
    logic eHitRt;
    logic mHitRs;
    logic mHitRt;
    logic lwStall;
    logic branchStall;
    logic jrStall;
    logic depStall;
    logic divStall;

    assign exc = (excepttypeM != 32'd0);

    // Forwarding: M result beats W result; register 0 is hard-wired and never forwarded
    assign forwardaE = (rsE != '0 && regwriteM && rsE == writeregM) ? 2'b10 :
                       (rsE != '0 && regwriteW && rsE == writeregW) ? 2'b01 : 2'b00;
    assign forwardbE = (rtE != '0 && regwriteM && rtE == writeregM) ? 2'b10 :
                       (rtE != '0 && regwriteW && rtE == writeregW) ? 2'b01 : 2'b00;
    assign forwardaD = (rsD != '0) && regwriteM && (rsD == writeregM);
    assign forwardbD = (rtD != '0) && regwriteM && (rtD == writeregM);

    // D-stage compare operands still in flight: an ALU result in E or a load in M
    assign eHitRs = regwriteE && (writeregE != '0) && (writeregE == rsD);
    assign eHitRt = regwriteE && (writeregE != '0) && (writeregE == rtD);
    assign mHitRs = memtoregM && (writeregM != '0) && (writeregM == rsD);
    assign mHitRt = memtoregM && (writeregM != '0) && (writeregM == rtD);

    assign lwStall     = memtoregE && (rtE != '0) && ((rtE == rsD) || (rtE == rtD));
    assign branchStall = branchD && (eHitRs || eHitRt || mHitRs || mHitRt);
    assign jrStall     = jrD && (eHitRs || mHitRs);
    assign depStall    = lwStall || branchStall || jrStall;

    // The divide holds E until its final (DONE) cycle, when the quotient is ready
    assign divStall = divE && (divState != DONE);
    assign div_busy = (divState == BUSY);
    assign div_done = (divState == DONE) && !exc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divState <= IDLE;
            divCount <= '0;
        end else begin
            divState <= divStateNext;
            divCount <= divCountNext;
        end
    end

    // divCount holds the BUSY cycles still to run, including the current one
    always_comb begin
        divStateNext = divState;
        divCountNext = divCount;
        case (divState)
            IDLE: begin
                if (divE && !mem_busyM) begin
                    if (DIV_CYCLES == 2) begin
                        divStateNext = DONE;
                    end else begin
                        divStateNext = BUSY;
                        divCountNext = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (!mem_busyM) begin
                    if (divCount <= CNT_W'(1)) begin
                        divStateNext = DONE;
                        divCountNext = '0;
                    end else begin
                        divCountNext = divCount - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                divStateNext = IDLE;
            end
            default: begin
                divStateNext = IDLE;
                divCountNext = '0;
            end
        endcase
        if (exc) begin
            divStateNext = IDLE;
            divCountNext = '0;
        end
    end

    // Stall/flush arbitration: exception, then SRAM wait, then divide, then data hazards
    always_comb begin
        stallF      = 1'b0;
        stallD      = 1'b0;
        stallE      = 1'b0;
        stallM      = 1'b0;
        flushF      = 1'b0;
        flushD      = 1'b0;
        flushE      = 1'b0;
        flushM      = 1'b0;
        flushW      = 1'b0;
        pc_redirect = 1'b0;
        newPC       = 32'd0;
        if (exc) begin
            flushF      = 1'b1;
            flushD      = 1'b1;
            flushE      = 1'b1;
            flushM      = 1'b1;
            flushW      = 1'b1;
            pc_redirect = 1'b1;
            newPC       = (excepttypeM == ERET_CODE) ? epcM : EXC_VECTOR;
        end else if (mem_busyM) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (divStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (depStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

endmodule
